// File: rtl/axi4_sample_ram_slave.sv
// rtl/axi4_sample_ram_slave.sv - AXI4-full responder backed by on-chip word RAM
//
// Serves as an on-chip sample store and a bench stand-in for PSRAM. The write
// path (AW/W/B) and the read path (AR/R) are independent FSMs. Each path has
// one outstanding transaction.
//
// Optional feature macro: AXI4_SAMPLE_RAM_WRAP_EN
//   defined   : WRAP bursts (BURST=10) with LEN+1 in {2,4,8,16} are served.
//   undefined : WRAP is unsupported. It returns SLVERR, performs no writes and reads return 0.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   S_AXI_AW*                write address channel (AWSIZE ignored)
//   S_AXI_W*                 write data channel with byte strobes
//   S_AXI_B*                 write response channel (OKAY / SLVERR)
//   S_AXI_AR*                read address channel (ARSIZE ignored)
//   S_AXI_R*                 read data channel (OKAY / SLVERR, RLAST)

module axi4_sample_ram_slave #(
    parameter int ID_W   = 1,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 24,
    parameter int DEPTH  = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ID_W-1:0]       S_AXI_AWID,
    input  logic [ADDR_W-1:0]     S_AXI_AWADDR,
    input  logic [7:0]            S_AXI_AWLEN,
    input  logic [2:0]            S_AXI_AWSIZE,
    input  logic [1:0]            S_AXI_AWBURST,
    input  logic                  S_AXI_AWVALID,
    output logic                  S_AXI_AWREADY,
    input  logic [DATA_W-1:0]     S_AXI_WDATA,
    input  logic [DATA_W/8-1:0]   S_AXI_WSTRB,
    input  logic                  S_AXI_WLAST,
    input  logic                  S_AXI_WVALID,
    output logic                  S_AXI_WREADY,
    output logic [ID_W-1:0]       S_AXI_BID,
    output logic [1:0]            S_AXI_BRESP,
    output logic                  S_AXI_BVALID,
    input  logic                  S_AXI_BREADY,
    input  logic [ID_W-1:0]       S_AXI_ARID,
    input  logic [ADDR_W-1:0]     S_AXI_ARADDR,
    input  logic [7:0]            S_AXI_ARLEN,
    input  logic [2:0]            S_AXI_ARSIZE,
    input  logic [1:0]            S_AXI_ARBURST,
    input  logic                  S_AXI_ARVALID,
    output logic                  S_AXI_ARREADY,
    output logic [ID_W-1:0]       S_AXI_RID,
    output logic [DATA_W-1:0]     S_AXI_RDATA,
    output logic [1:0]            S_AXI_RRESP,
    output logic                  S_AXI_RLAST,
    output logic                  S_AXI_RVALID,
    input  logic                  S_AXI_RREADY
);

    localparam int IDX_W  = ADDR_W - 2;
    localparam int RAM_AW = $clog2(DEPTH);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    // ---------------- write path ----------------
    w_state_t         w_state, w_state_nxt;
    logic [ID_W-1:0]  w_id;
    logic [IDX_W-1:0] w_idx, w_idx_inc, w_idx_nxt;
    logic [7:0]       w_len, w_beat;
    logic [1:0]       w_burst;
    logic             w_err;
    logic             aw_rdy, w_rdy, b_vld;
    logic             w_bok, w_oor, w_last_beat, w_beat_err, w_fire, w_we;

    always_ff @(posedge clk) begin
        if (rst) w_state <= W_IDLE;
        else     w_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = w_state;
        aw_rdy      = 1'b0;
        w_rdy       = 1'b0;
        b_vld       = 1'b0;
        case (w_state)
            W_IDLE: begin
                aw_rdy = 1'b1;
                if (S_AXI_AWVALID) w_state_nxt = W_DATA;
            end
            W_DATA: begin
                w_rdy = 1'b1;
                if (S_AXI_WVALID && w_last_beat) w_state_nxt = W_RESP;
            end
            W_RESP: begin
                b_vld = 1'b1;
                if (S_AXI_BREADY) w_state_nxt = W_IDLE;
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    // Burst legality and next-beat index for the latched write burst
    always_comb begin
        w_bok     = 1'b0;
        w_idx_inc = w_idx + IDX_W'(1);
        w_idx_nxt = w_idx;
        case (w_burst)
            2'b00: w_bok = 1'b1;
            2'b01: begin
                w_bok     = 1'b1;
                w_idx_nxt = w_idx_inc;
            end
`ifdef AXI4_SAMPLE_RAM_WRAP_EN
            2'b10: begin
                // LEN is 2^n-1 when legal, so it doubles as the wrap mask
                w_bok     = (w_len == 8'd1) || (w_len == 8'd3) ||
                            (w_len == 8'd7) || (w_len == 8'd15);
                w_idx_nxt = (w_idx & ~IDX_W'(w_len)) | (w_idx_inc & IDX_W'(w_len));
            end
`endif
            default: w_bok = 1'b0;
        endcase
    end

    assign w_oor       = 32'(w_idx) >= 32'(DEPTH);
    assign w_last_beat = (w_beat == w_len);
    assign w_fire      = (w_state == W_DATA) && S_AXI_WVALID && !rst;
    assign w_beat_err  = w_oor || !w_bok || (S_AXI_WLAST != w_last_beat);
    assign w_we        = w_fire && w_bok && !w_oor;

    always_ff @(posedge clk) begin
        if (rst) begin
            w_id    <= '0;
            w_idx   <= '0;
            w_len   <= '0;
            w_burst <= '0;
            w_beat  <= '0;
            w_err   <= 1'b0;
        end else begin
            if (w_state == W_IDLE && S_AXI_AWVALID) begin
                w_id    <= S_AXI_AWID;
                w_idx   <= S_AXI_AWADDR[ADDR_W-1:2];
                w_len   <= S_AXI_AWLEN;
                w_burst <= S_AXI_AWBURST;
                w_beat  <= '0;
                w_err   <= 1'b0;
            end
            if (w_fire) begin
                w_beat <= w_beat + 8'd1;
                w_idx  <= w_idx_nxt;
                w_err  <= w_err | w_beat_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (S_AXI_WSTRB[i]) mem[w_idx[RAM_AW-1:0]][8*i +: 8] <= S_AXI_WDATA[8*i +: 8];
            end
        end
    end

    assign S_AXI_AWREADY = aw_rdy & ~rst;
    assign S_AXI_WREADY  = w_rdy & ~rst;
    assign S_AXI_BVALID  = b_vld & ~rst;
    assign S_AXI_BRESP   = (b_vld && w_err && !rst) ? 2'b10 : 2'b00;
    assign S_AXI_BID     = w_id;

    // ---------------- read path ----------------
    r_state_t         r_state, r_state_nxt;
    logic [ID_W-1:0]  r_id;
    logic [IDX_W-1:0] r_idx, r_idx_inc, r_idx_nxt;
    logic [7:0]       r_len, r_beat;
    logic [1:0]       r_burst;
    logic             r_err;
    logic [DATA_W-1:0] r_data;
    logic             ar_rdy, r_vld, r_bok, r_oor, r_last_beat;

    always_ff @(posedge clk) begin
        if (rst) r_state <= R_IDLE;
        else     r_state <= r_state_nxt;
    end

    always_comb begin
        r_state_nxt = r_state;
        ar_rdy      = 1'b0;
        r_vld       = 1'b0;
        case (r_state)
            R_IDLE: begin
                ar_rdy = 1'b1;
                if (S_AXI_ARVALID) r_state_nxt = R_FETCH;
            end
            R_FETCH: r_state_nxt = R_DATA;
            R_DATA: begin
                r_vld = 1'b1;
                if (S_AXI_RREADY) r_state_nxt = r_last_beat ? R_IDLE : R_FETCH;
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        r_bok     = 1'b0;
        r_idx_inc = r_idx + IDX_W'(1);
        r_idx_nxt = r_idx;
        case (r_burst)
            2'b00: r_bok = 1'b1;
            2'b01: begin
                r_bok     = 1'b1;
                r_idx_nxt = r_idx_inc;
            end
`ifdef AXI4_SAMPLE_RAM_WRAP_EN
            2'b10: begin
                r_bok     = (r_len == 8'd1) || (r_len == 8'd3) ||
                            (r_len == 8'd7) || (r_len == 8'd15);
                r_idx_nxt = (r_idx & ~IDX_W'(r_len)) | (r_idx_inc & IDX_W'(r_len));
            end
`endif
            default: r_bok = 1'b0;
        endcase
    end

    assign r_oor       = 32'(r_idx) >= 32'(DEPTH);
    assign r_last_beat = (r_beat == r_len);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_id    <= '0;
            r_idx   <= '0;
            r_len   <= '0;
            r_burst <= '0;
            r_beat  <= '0;
            r_err   <= 1'b0;
        end else begin
            if (r_state == R_IDLE && S_AXI_ARVALID) begin
                r_id    <= S_AXI_ARID;
                r_idx   <= S_AXI_ARADDR[ADDR_W-1:2];
                r_len   <= S_AXI_ARLEN;
                r_burst <= S_AXI_ARBURST;
                r_beat  <= '0;
            end
            // Beat status is frozen at fetch so R outputs hold while stalled
            if (r_state == R_FETCH) r_err <= r_oor || !r_bok;
            if (r_state == R_DATA && S_AXI_RREADY && !r_last_beat) begin
                r_beat <= r_beat + 8'd1;
                r_idx  <= r_idx_nxt;
            end
        end
    end

    // Nonblocking read against the write block gives read-first on a collision
    always_ff @(posedge clk) begin
        if (r_state == R_FETCH) r_data <= mem[r_idx[RAM_AW-1:0]];
    end

    assign S_AXI_ARREADY = ar_rdy & ~rst;
    assign S_AXI_RVALID  = r_vld & ~rst;
    assign S_AXI_RDATA   = (r_vld && !r_err && !rst) ? r_data : '0;
    assign S_AXI_RRESP   = (r_vld && r_err && !rst) ? 2'b10 : 2'b00;
    assign S_AXI_RLAST   = r_vld && r_last_beat && !rst;
    assign S_AXI_RID     = r_id;

    logic unused_inputs;
    assign unused_inputs = ^{S_AXI_AWSIZE, S_AXI_ARSIZE, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

endmodule

// File: doc/axi4_sample_ram_slave.md
Name: axi4_sample_ram_slave

Overview:
AXI4-full responder backed by on-chip word RAM. It accepts the address, write-data, write-response, read-address and read-data channels that the mic capture/playback logic issues. It is the slave end of the same bus the psram_ip controller terminates, and serves as an on-chip sample store and a bench stand-in for PSRAM. Write and read paths are independent FSMs; each path has one outstanding transaction.

Parameters:
ID_W, 1, width of AXI ID fields
DATA_W, 32, data bus width in bits; fixed beat size of DATA_W/8 bytes
ADDR_W, 24, AXI byte-address width
DEPTH, 4096, RAM depth in DATA_W words

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
S_AXI_AWID  in  ID_W  write ID
S_AXI_AWADDR  in  ADDR_W  write start byte address
S_AXI_AWLEN  in  8  beats minus 1
S_AXI_AWSIZE  in  3  ignored
S_AXI_AWBURST  in  2  burst type
S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  AW handshake
S_AXI_WDATA  in  DATA_W  write data
S_AXI_WSTRB  in  DATA_W/8  byte enables
S_AXI_WLAST  in  1  last write beat
S_AXI_WVALID / S_AXI_WREADY  in/out  1  W handshake
S_AXI_BID  out  ID_W  response ID
S_AXI_BRESP  out  2  00 OKAY, 10 SLVERR
S_AXI_BVALID / S_AXI_BREADY  out/in  1  B handshake
S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST  in  ID_W/ADDR_W/8/3/2  read request fields; ARSIZE ignored
S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  AR handshake
S_AXI_RID  out  ID_W  read ID
S_AXI_RDATA  out  DATA_W  read data
S_AXI_RRESP  out  2  00 OKAY, 10 SLVERR
S_AXI_RLAST  out  1  final read beat
S_AXI_RVALID / S_AXI_RREADY  out/in  1  R handshake

Behaviour:
- Reset: every output 0; both FSMs go to IDLE; in-flight bursts are dropped; RAM contents are retained. AWREADY and ARREADY rise in the first cycle after rst falls.
- Addressing: word index = ADDR[ADDR_W-1:2]; ADDR[1:0] is ignored. INCR and FIXED bursts are supported. INCR adds 1 to the index per beat. FIXED keeps the index constant. A beat with index >= DEPTH is out of range.
- Write FSM W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: AWREADY=1, WREADY=0. On AW handshake, latch ID, index, LEN and BURST; go to W_DATA and clear the error flag.
  - W_DATA: AWREADY=0, WREADY=1. Each W handshake writes the RAM bytes whose WSTRB bit is set, unless the beat is out of range; the beat counter increments. When beat == LEN, go to W_RESP.
  - Error flag sets on an out-of-range beat, on WLAST=1 before the last beat, on WLAST=0 on the last beat, or on an unsupported BURST. Once set it holds for the rest of the burst.
  - W_RESP: BVALID=1, BRESP=10 if the error flag is set else 00, BID=latched ID. Hold until BREADY, then W_IDLE. No new AW is accepted before B completes.
- Read FSM R_IDLE -> R_FETCH -> R_DATA:
  - R_IDLE: ARREADY=1. On AR handshake, latch fields; go to R_FETCH.
  - R_FETCH: one cycle of synchronous RAM read; go to R_DATA.
  - R_DATA: RVALID=1. RDATA, RRESP, RID and RLAST stay stable until RREADY. An out-of-range or unsupported-burst beat returns RDATA=0 with RRESP=10. RLAST=1 only on beat LEN.
  - On handshake: if last, go to R_IDLE, else advance the index and go to R_FETCH.
  - Latency: AR handshake at cycle N gives RVALID at N+2. There is one bubble cycle between beats.
- Same-cycle write and read of the same word: the read returns the old data (read-first); the write completes normally.
- BURST=11 (reserved) is always SLVERR, with no RAM writes.

Optional Feature:
- Macro: AXI4_SAMPLE_RAM_WRAP_EN.
- Defined: BURST=10 (WRAP) is supported for LEN+1 in {2,4,8,16}. The index wraps within an aligned block of LEN+1 words. Any other LEN with WRAP gives SLVERR and no writes.
- Undefined: BURST=10 is treated as unsupported: SLVERR on every beat, no RAM writes, and reads return 0. All other timing is unchanged.

Test Plan:
- Write 0x12345678 to 0x000004 (LEN 0, WSTRB F) -> BRESP 00. Read 0x000004 -> RDATA 0x12345678, RRESP 00, RLAST 1, RVALID 2 cycles after AR handshake.
- Then write 0xAAAAAAAA with WSTRB 0011 -> readback 0x1234AAAA.
- INCR write at 0x000010, LEN 3, data 1,2,3,4 -> read burst returns 1,2,3,4 with RLAST only on 4, RID = ARID.
- Write to byte address DEPTH*4 -> BRESP 10 and the RAM is unchanged. Read of the same address -> RDATA 0, RRESP 10.
- Hold BREADY low 10 cycles -> BVALID stays 1 and BRESP stable; AWREADY stays 0 and a queued AW is accepted only after the B handshake.
- Assert rst after read beat 2 of a LEN 3 burst -> RVALID 0 next cycle, ARREADY 1 after release; a re-read returns the original data.
- With the macro defined, a WRAP write LEN 3 at 0x000018 -> word indices 6,7,4,5 written.
